// File: rtl/memory_pkg.sv
// rtl/memory_pkg.sv - shared owner/state encodings and data-window defaults for the memory subsystem
package memory_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_OWN  = 2'd1,
    ST_DMA_OWN  = 2'd2,
    ST_DMA_LOCK = 2'd3
  } arb_state_e;

  localparam logic [31:0] DATA_LO_DEF = 32'h0000_0400;
  localparam logic [31:0] DATA_HI_DEF = 32'h0000_0FFF;
  localparam logic [31:0] ERR_PATTERN = 32'hDEAD_BEEF;

endpackage

// File: rtl/addr_window_check.sv
// rtl/addr_window_check.sv - combinational inclusive address window test
module addr_window_check
  import memory_pkg::*;
#(
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] WIN_LO = ADDR_W'(DATA_LO_DEF),
  parameter logic [ADDR_W-1:0] WIN_HI = ADDR_W'(DATA_HI_DEF)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              in_range
);

  assign in_range = (addr >= WIN_LO) && (addr <= WIN_HI);

endmodule

// File: rtl/data_port_arbiter.sv
// rtl/data_port_arbiter.sv - CPU/DMA arbiter for memory port B with bounds check, fairness and burst lock
module data_port_arbiter
  import memory_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] DATA_LO    = ADDR_W'(DATA_LO_DEF),
  parameter logic [ADDR_W-1:0] DATA_HI    = ADDR_W'(DATA_HI_DEF),
  parameter int                MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [3:0]        dma_be,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_err,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int                  STREAK_W   = $clog2(MAX_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

  arb_state_e           state_q, state_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;
  owner_e               rtag_q, rtag_d;
  logic                 rerr_q, rerr_d;
  logic [DATA_W-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]    dma_rdata_q, dma_rdata_d;

  owner_e               winner;
  logic                 win_we;
  logic [3:0]           win_be;
  logic [ADDR_W-1:0]    win_addr;
  logic [DATA_W-1:0]    win_wdata;
  logic                 win_in_range;
  logic [DATA_W-1:0]    ret_data;

  // Outputs are forced idle while reset is held, even with requests pending.
  always_comb begin
    winner = OWN_NONE;
    if (!rst_n) begin
      winner = OWN_NONE;
    end else if (state_q == ST_DMA_LOCK && dma_lock) begin
      winner = dma_req ? OWN_DMA : OWN_NONE;
    end else if (cpu_req && dma_req) begin
      winner = (streak_q == STREAK_MAX) ? OWN_DMA : OWN_CPU;
    end else if (cpu_req) begin
      winner = OWN_CPU;
    end else if (dma_req) begin
      winner = OWN_DMA;
    end
  end

  always_comb begin
    win_we    = cpu_we;
    win_be    = cpu_be;
    win_addr  = cpu_addr;
    win_wdata = cpu_wdata;
    if (winner == OWN_DMA) begin
      win_we    = dma_we;
      win_be    = dma_be;
      win_addr  = dma_addr;
      win_wdata = dma_wdata;
    end
  end

  addr_window_check #(
    .ADDR_W (ADDR_W),
    .WIN_LO (DATA_LO),
    .WIN_HI (DATA_HI)
  ) u_window (
    .addr     (win_addr),
    .in_range (win_in_range)
  );

  assign cpu_gnt  = (winner == OWN_CPU);
  assign dma_gnt  = (winner == OWN_DMA);
  assign cpu_err  = cpu_gnt && !win_in_range;
  assign dma_err  = dma_gnt && !win_in_range;
  assign mem_en   = (winner != OWN_NONE) && win_in_range;
  assign mem_we   = (mem_en && win_we) ? win_be : 4'h0;
  assign mem_addr = win_addr;
  assign mem_din  = win_wdata;

  // A rejected read returns the error pattern instead of whatever the memory drives.
  assign ret_data   = rerr_q ? DATA_W'(ERR_PATTERN) : mem_dout;
  assign cpu_rvalid = (rtag_q == OWN_CPU);
  assign dma_rvalid = (rtag_q == OWN_DMA);
  assign cpu_rdata  = cpu_rvalid ? ret_data : cpu_rdata_q;
  assign dma_rdata  = dma_rvalid ? ret_data : dma_rdata_q;

  always_comb begin
    state_d     = ST_IDLE;
    streak_d    = streak_q;
    rtag_d      = OWN_NONE;
    rerr_d      = !win_in_range;
    cpu_rdata_d = cpu_rdata;
    dma_rdata_d = dma_rdata;

    case (winner)
      OWN_DMA:  state_d = dma_lock ? ST_DMA_LOCK : ST_DMA_OWN;
      OWN_CPU:  state_d = ST_CPU_OWN;
      default:  state_d = (state_q == ST_DMA_LOCK && dma_lock) ? ST_DMA_LOCK : ST_IDLE;
    endcase

    if (winner != OWN_NONE && !win_we) begin
      rtag_d = winner;
    end

    if (winner == OWN_DMA || !dma_req) begin
      streak_d = '0;
    end else if (winner == OWN_CPU && streak_q != STREAK_MAX) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      rtag_q      <= OWN_NONE;
      rerr_q      <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      rtag_q      <= rtag_d;
      rerr_q      <= rerr_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

endmodule
